// File: rtl/trig_pkg.sv
// Shared definitions for the trigger-type serialiser: type width, the alignment
// type code, frame length and the FSM state encoding.
package trig_pkg;

  localparam int unsigned TRIG_TYPE_W     = 3;
  localparam int unsigned TRIG_FRAME_BITS = 4;
  localparam int unsigned TRIG_ST_W       = 3;

  typedef logic [TRIG_TYPE_W-1:0] trig_type_t;

  localparam trig_type_t TRIG_TYPE_ALIGN = 3'b010;

  typedef enum logic [TRIG_ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT0  = 3'd2,
    ST_BIT1  = 3'd3,
    ST_BIT2  = 3'd4,
    ST_GAP   = 3'd5
  } trig_state_e;

  // True when the receiver will treat this type as the alignment trigger.
  function automatic logic is_align(input trig_type_t t);
    return t == TRIG_TYPE_ALIGN;
  endfunction

  // Cycles from one pop to the next when frames run back to back.
  function automatic int unsigned frame_period(input int unsigned gap_cycles);
    return TRIG_FRAME_BITS + 1 + gap_cycles;
  endfunction

endpackage

// File: rtl/trig_type_ser_if.sv
// Request and serial-output bundle between a trigger source and trig_type_ser.
interface trig_type_ser_if
  import trig_pkg::*;
#(
  parameter int unsigned OVF_W = 8
) ();

  logic             in_live;
  logic             trig_req;
  trig_type_t       trig_type;
  logic             req_ready;
  logic             trig_to_adc;
  logic             busy;
  logic             frame_done;
  logic [OVF_W-1:0] ovf_cnt;

  modport master (
    output in_live, trig_req, trig_type,
    input  req_ready, trig_to_adc, busy, frame_done, ovf_cnt
  );

  modport slave (
    input  in_live, trig_req, trig_type,
    output req_ready, trig_to_adc, busy, frame_done, ovf_cnt
  );

endinterface

// File: rtl/trig_req_fifo.sv
// Synchronous show-ahead FIFO for queued trigger types; flush empties it in one edge.
module trig_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/trig_type_ser.sv
// Queues trigger requests and serialises each as start bit, three type bits
// (LSB first) and a forced low gap onto trig_to_adc.
module trig_type_ser
  import trig_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned OVF_W      = 8
) (
  input logic            clk,
  input logic            rst_n,
  trig_type_ser_if.slave bus
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  trig_state_e      state;
  trig_state_e      state_nx;
  trig_type_t       type_r;
  trig_type_t       type_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nx;
  logic             out_q;
  logic             out_nx;
  logic             done_q;
  logic             done_nx;
  logic             busy_q;
  logic             busy_nx;
  logic [OVF_W-1:0] ovf_q;
  logic [OVF_W-1:0] ovf_nx;

  logic             push;
  logic             pop;
  trig_type_t       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;

  // Full is judged before the edge, so a same-edge pop never frees a slot for the push.
  assign push = bus.trig_req && bus.in_live && !fifo_full;
  assign pop  = bus.in_live && (state == ST_IDLE) && !fifo_empty;

  trig_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TRIG_TYPE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!bus.in_live),
    .wr    (push),
    .wdata (bus.trig_type),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      type_r  <= '0;
      gap_cnt <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state   <= state_nx;
      type_r  <= type_nx;
      gap_cnt <= gap_nx;
      out_q   <= out_nx;
      done_q  <= done_nx;
      busy_q  <= busy_nx;
      ovf_q   <= ovf_nx;
    end
  end

  // Next state and the value each state puts on the line at the coming edge.
  always_comb begin
    state_nx = state;
    type_nx  = type_r;
    gap_nx   = gap_cnt;
    out_nx   = 1'b0;
    done_nx  = 1'b0;
    busy_nx  = 1'b0;
    ovf_nx   = ovf_q;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          type_nx  = fifo_rdata;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        out_nx   = 1'b1;
        state_nx = ST_BIT0;
      end
      ST_BIT0: begin
        out_nx   = type_r[0];
        state_nx = ST_BIT1;
      end
      ST_BIT1: begin
        out_nx   = type_r[1];
        state_nx = ST_BIT2;
      end
      ST_BIT2: begin
        out_nx   = type_r[2];
        gap_nx   = GAP_W'(GAP_CYCLES - 1);
        state_nx = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (bus.trig_req && fifo_full && (ovf_q != '1)) ovf_nx = ovf_q + OVF_W'(1);

    // A pop only happens when leaving IDLE, so post-edge occupancy reduces to this.
    busy_nx = (state_nx != ST_IDLE) || push || !fifo_empty;

    if (!bus.in_live) begin
      state_nx = ST_IDLE;
      gap_nx   = '0;
      out_nx   = 1'b0;
      done_nx  = 1'b0;
      busy_nx  = 1'b0;
      ovf_nx   = '0;
    end
  end

  assign bus.req_ready   = !fifo_full;
  assign bus.trig_to_adc = out_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.ovf_cnt     = ovf_q;

endmodule
